pipeline_control: RTL and testbench

Consumes the hazard/branch/jump decisions and the cache handshakes (ihit, dhit) and drives every pipeline-latch enable and flush plus the PC enable. It sequences data-access completion: the data request is suppressed and the load data is held once dhit arrives while ihit is still pending. It also sequences halt drain and keeps saturating stall/flush performance counters. Sits in the datapath top between hazard_unit, the four pipeline latches, and the cache request lines.

---
 rtl/cpu_types_pkg.sv | 23 ++
 rtl/pipeline_control_if.sv | 50 +++++
 rtl/sat_counter.sv | 40 ++++
 rtl/pipeline_control.sv | 148 ++++++++++++++
 tb/tb_pipeline_control.sv | 256 +++++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_types_pkg.sv
// ---------------------------------------------------------------------------
// cpu_types_pkg: shared types for the pipeline control slice.  Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package cpu_types_pkg;

  localparam int DATA_W = 32;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DHOLD = 2'd1,
    HALT  = 2'd2
  } pctl_state_t;

  // Raw data request still live toward the cache once suppression is applied.
  function automatic logic live_dreq(input logic ren, input logic wen, input logic suppress);
    return (ren | wen) & ~suppress;
  endfunction

endpackage

`default_nettype wire

// File: rtl/pipeline_control_if.sv
// ---------------------------------------------------------------------------
// pipeline_control_if: cache/hazard inputs and latch-control outputs.  Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface pipeline_control_if #(
  parameter int CNT_W = 32
);
  import cpu_types_pkg::*;

  logic              ihit;
  logic              dhit;
  logic              dmemREN;
  logic              dmemWEN;
  logic [DATA_W-1:0] dmemload;
  logic              hazard;
  logic              branch;
  logic              jump;
  logic              halt_mem;

  logic              pc_en;
  logic              if_id_en;
  logic              id_ex_en;
  logic              ex_mem_en;
  logic              mem_wb_en;
  logic              if_id_flush;
  logic              id_ex_flush;
  logic              dmem_suppress;
  logic [DATA_W-1:0] dload_out;
  logic              halt_out;
  logic [CNT_W-1:0]  stall_cnt;
  logic [CNT_W-1:0]  flush_cnt;

  // Control block side.
  modport master (
    input  ihit, dhit, dmemREN, dmemWEN, dmemload, hazard, branch, jump, halt_mem,
    output pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en, if_id_flush, id_ex_flush,
    output dmem_suppress, dload_out, halt_out, stall_cnt, flush_cnt
  );

  // Datapath side.
  modport slave (
    output ihit, dhit, dmemREN, dmemWEN, dmemload, hazard, branch, jump, halt_mem,
    input  pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en, if_id_flush, id_ex_flush,
    input  dmem_suppress, dload_out, halt_out, stall_cnt, flush_cnt
  );

endinterface

`default_nettype wire

// File: rtl/sat_counter.sv
// ---------------------------------------------------------------------------
// sat_counter: W-bit up counter that sticks at all-ones.  Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module sat_counter #(
  parameter int W = 32
) (
  input  logic         CLK,
  input  logic         nRST,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  localparam logic [W-1:0] C_MAX = {W{1'b1}};
  localparam logic [W-1:0] C_ONE = W'(1);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (inc && (cnt_q != C_MAX)) begin
      cnt_d = cnt_q + C_ONE;
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

`default_nettype wire

// File: rtl/pipeline_control.sv
// ---------------------------------------------------------------------------
// pipeline_control: latch enables/flushes, data-access sequencing, halt drain
// and saturating stall/flush counters.  Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module pipeline_control
  import cpu_types_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input logic               CLK,
  input logic               nRST,
  pipeline_control_if.master bus
);

  pctl_state_t       state_q;
  pctl_state_t       state_d;
  logic [DATA_W-1:0] dload_q;
  logic [DATA_W-1:0] dload_d;
  logic              halt_q;
  logic              halt_d;

  logic dreq;
  logic advance;
  logic capture;
  logic pc_en;
  logic if_id_en;
  logic id_ex_en;
  logic ex_mem_en;
  logic mem_wb_en;
  logic if_id_flush;
  logic id_ex_flush;
  logic dmem_suppress;
  logic stall_inc;
  logic flush_inc;

  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  always_comb begin
    state_d       = state_q;
    dload_d       = dload_q;
    advance       = 1'b0;
    capture       = 1'b0;
    pc_en         = 1'b0;
    if_id_en      = 1'b0;
    id_ex_en      = 1'b0;
    ex_mem_en     = 1'b0;
    mem_wb_en     = 1'b0;
    if_id_flush   = 1'b0;
    id_ex_flush   = 1'b0;
    dmem_suppress = (state_q != RUN);
    dreq          = live_dreq(bus.dmemREN, bus.dmemWEN, dmem_suppress);

    case (state_q)
      RUN: begin
        advance = bus.ihit & (~dreq | bus.dhit);
        capture = dreq & bus.dhit & ~bus.ihit;
      end
      DHOLD: begin
        advance = bus.ihit;
      end
      default: begin
        advance = 1'b0;
      end
    endcase

    if (advance) begin
      pc_en     = 1'b1;
      if_id_en  = 1'b1;
      id_ex_en  = 1'b1;
      ex_mem_en = 1'b1;
      mem_wb_en = 1'b1;
      // A load-use bubble outranks a redirect; the redirect re-resolves next cycle.
      if (bus.hazard) begin
        pc_en       = 1'b0;
        if_id_en    = 1'b0;
        id_ex_flush = 1'b1;
      end else if (bus.branch | bus.jump) begin
        if_id_flush = 1'b1;
      end
      state_d = bus.halt_mem ? HALT : RUN;
    end else if (capture) begin
      state_d = DHOLD;
      dload_d = bus.dmemload;
    end

    halt_d = (state_d == HALT);

    // Reset is asynchronous, so the combinational controls are silenced with it.
    if (!nRST) begin
      pc_en         = 1'b0;
      if_id_en      = 1'b0;
      id_ex_en      = 1'b0;
      ex_mem_en     = 1'b0;
      mem_wb_en     = 1'b0;
      if_id_flush   = 1'b0;
      id_ex_flush   = 1'b0;
      dmem_suppress = 1'b0;
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q <= RUN;
      dload_q <= '0;
      halt_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      dload_q <= dload_d;
      halt_q  <= halt_d;
    end
  end

  assign stall_inc = nRST & (state_q != HALT) & ~pc_en;
  assign flush_inc = nRST & (state_q != HALT) & if_id_flush;

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .CLK  (CLK),
    .nRST (nRST),
    .inc  (stall_inc),
    .cnt  (stall_cnt)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .CLK  (CLK),
    .nRST (nRST),
    .inc  (flush_inc),
    .cnt  (flush_cnt)
  );

  assign bus.pc_en         = pc_en;
  assign bus.if_id_en      = if_id_en;
  assign bus.id_ex_en      = id_ex_en;
  assign bus.ex_mem_en     = ex_mem_en;
  assign bus.mem_wb_en     = mem_wb_en;
  assign bus.if_id_flush   = if_id_flush;
  assign bus.id_ex_flush   = id_ex_flush;
  assign bus.dmem_suppress = dmem_suppress;
  assign bus.dload_out     = (state_q == DHOLD) ? dload_q : bus.dmemload;
  assign bus.halt_out      = halt_q;
  assign bus.stall_cnt     = stall_cnt;
  assign bus.flush_cnt     = flush_cnt;

endmodule

`default_nettype wire

// File: tb/tb_pipeline_control.sv
// ---------------------------------------------------------------------------
// tb_pipeline_control: directed stimulus, behavioural model, per-cycle compare.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_pipeline_control;

  logic CLK;
  logic nRST;

  pipeline_control_if #(.CNT_W(32)) bus ();
  pipeline_control_if #(.CNT_W(4))  bus4 ();

  pipeline_control #(.CNT_W(32)) dut (
    .CLK  (CLK),
    .nRST (nRST),
    .bus  (bus)
  );

  pipeline_control #(.CNT_W(4)) dut4 (
    .CLK  (CLK),
    .nRST (nRST),
    .bus  (bus4)
  );

  // The narrow-counter instance sees exactly the same stimulus.
  assign bus4.ihit     = bus.ihit;
  assign bus4.dhit     = bus.dhit;
  assign bus4.dmemREN  = bus.dmemREN;
  assign bus4.dmemWEN  = bus.dmemWEN;
  assign bus4.dmemload = bus.dmemload;
  assign bus4.hazard   = bus.hazard;
  assign bus4.branch   = bus.branch;
  assign bus4.jump     = bus.jump;
  assign bus4.halt_mem = bus.halt_mem;

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: pending captured load, halted flag, plain counts.
  bit              m_held   = 1'b0;
  bit              m_halted = 1'b0;
  logic [31:0]     m_data   = '0;
  longint unsigned m_stall  = 0;
  longint unsigned m_flush  = 0;

  bit          e_go, e_req, e_pc, e_en_if, e_en_rest, e_fl_if, e_fl_id, e_sup;
  logic [31:0] e_dload;

  function automatic longint unsigned cap(input longint unsigned v, input int w);
    longint unsigned mx;
    mx = (64'd1 << w) - 64'd1;
    return (v > mx) ? mx : v;
  endfunction

  task automatic compute_exp();
    e_go = 0; e_req = 0; e_pc = 0; e_en_if = 0; e_en_rest = 0;
    e_fl_if = 0; e_fl_id = 0; e_sup = 0;
    e_dload = m_held ? m_data : bus.dmemload;
    if (nRST && !m_halted) begin
      e_sup = m_held;
      e_req = (bus.dmemREN || bus.dmemWEN) && !m_held;
      e_go  = m_held ? bus.ihit : (bus.ihit && (!e_req || bus.dhit));
      if (e_go) begin
        e_en_rest = 1;
        e_pc      = !bus.hazard;
        e_en_if   = !bus.hazard;
        e_fl_id   = bus.hazard;
        e_fl_if   = !bus.hazard && (bus.branch || bus.jump);
      end
    end else if (nRST) begin
      e_sup = 1;
    end
  endtask

  always @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      m_held = 0; m_halted = 0; m_data = '0; m_stall = 0; m_flush = 0;
    end else begin
      compute_exp();
      if (!m_halted) begin
        if (!e_pc)   m_stall++;
        if (e_fl_if) m_flush++;
        if (e_go) begin
          m_held = 0;
          if (bus.halt_mem) m_halted = 1;
        end else if (!m_held && e_req && bus.dhit && !bus.ihit) begin
          m_held = 1;
          m_data = bus.dmemload;
        end
      end
    end
  end

  always @(negedge CLK) begin
    compute_exp();
    chk("pc_en",         bus.pc_en,         e_pc);
    chk("if_id_en",      bus.if_id_en,      e_en_if);
    chk("id_ex_en",      bus.id_ex_en,      e_en_rest);
    chk("ex_mem_en",     bus.ex_mem_en,     e_en_rest);
    chk("mem_wb_en",     bus.mem_wb_en,     e_en_rest);
    chk("if_id_flush",   bus.if_id_flush,   e_fl_if);
    chk("id_ex_flush",   bus.id_ex_flush,   e_fl_id);
    chk("dmem_suppress", bus.dmem_suppress, e_sup);
    chk("dload_out",     bus.dload_out,     e_dload);
    chk("halt_out",      bus.halt_out,      m_halted);
    chk("stall_cnt",     bus.stall_cnt,     cap(m_stall, 32));
    chk("flush_cnt",     bus.flush_cnt,     cap(m_flush, 32));
    chk("stall_cnt4",    bus4.stall_cnt,    cap(m_stall, 4));
    chk("flush_cnt4",    bus4.flush_cnt,    cap(m_flush, 4));
  end

  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  longint unsigned s0, f0;

  initial begin
    nRST = 1'b0;
    bus.ihit = 1'b1; bus.dhit = 1'b0; bus.dmemREN = 1'b0; bus.dmemWEN = 1'b0;
    bus.dmemload = '0; bus.hazard = 1'b0; bus.branch = 1'b0; bus.jump = 1'b0;
    bus.halt_mem = 1'b0;
    repeat (2) cyc();
    chk("rst_pc_en", bus.pc_en, 1'b0);
    chk("rst_mem_wb_en", bus.mem_wb_en, 1'b0);
    chk("rst_stall", bus.stall_cnt, 0);
    chk("rst_halt", bus.halt_out, 1'b0);
    nRST = 1'b1;
    #1;
    chk("alu_pc_en", bus.pc_en, 1'b1);
    chk("alu_if_id_en", bus.if_id_en, 1'b1);
    chk("alu_if_id_flush", bus.if_id_flush, 1'b0);
    s0 = bus.stall_cnt;
    repeat (3) cyc();
    chk("alu_stall_delta", bus.stall_cnt - s0, 0);

    // Data hit arrives before the instruction fetch completes.
    bus.dmemREN = 1'b1; bus.dhit = 1'b1; bus.ihit = 1'b0; bus.dmemload = 32'h1234;
    s0 = bus.stall_cnt;
    #1 chk("ld_first_pc_en", bus.pc_en, 1'b0);
    cyc();
    bus.dhit = 1'b0; bus.dmemload = 32'h0;
    #1;
    chk("ld_suppress", bus.dmem_suppress, 1'b1);
    chk("ld_dload_held", bus.dload_out, 32'h1234);
    cyc();
    cyc();
    bus.ihit = 1'b1; bus.dmemREN = 1'b0;
    #1 chk("ld_release_pc_en", bus.pc_en, 1'b1);
    cyc();
    chk("ld_stall_delta", bus.stall_cnt - s0, 3);
    chk("ld_back_to_run", bus.dmem_suppress, 1'b0);

    // Data miss with fetch ready: frozen until dhit.
    bus.dmemREN = 1'b1; bus.dhit = 1'b0; bus.ihit = 1'b1;
    s0 = bus.stall_cnt;
    for (int i = 0; i < 5; i++) begin
      #1 chk("miss_pc_en", bus.pc_en, 1'b0);
      cyc();
    end
    bus.dhit = 1'b1;
    #1 chk("miss_hit_mem_wb_en", bus.mem_wb_en, 1'b1);
    cyc();
    bus.dmemREN = 1'b0; bus.dhit = 1'b0;
    chk("miss_stall_delta", bus.stall_cnt - s0, 5);
    chk("miss_stays_run", bus.dmem_suppress, 1'b0);

    // Hazard beats branch, then a jump flushes IF/ID.
    bus.hazard = 1'b1; bus.branch = 1'b1;
    #1;
    chk("hz_pc_en", bus.pc_en, 1'b0);
    chk("hz_if_id_en", bus.if_id_en, 1'b0);
    chk("hz_id_ex_flush", bus.id_ex_flush, 1'b1);
    chk("hz_if_id_flush", bus.if_id_flush, 1'b0);
    cyc();
    bus.hazard = 1'b0; bus.branch = 1'b0; bus.jump = 1'b1;
    #1;
    chk("jmp_if_id_flush", bus.if_id_flush, 1'b1);
    chk("jmp_pc_en", bus.pc_en, 1'b1);
    cyc();
    bus.jump = 1'b0;
    chk("jmp_flush_cnt", bus.flush_cnt, 1);
    chk("stall_total", bus.stall_cnt, 9);
    chk("stall_total4", bus4.stall_cnt, 9);

    // Saturation of the 4-bit instance.
    bus.ihit = 1'b0;
    repeat (20) cyc();
    bus.ihit = 1'b1;
    chk("sat_stall32", bus.stall_cnt, 29);
    chk("sat_stall4", bus4.stall_cnt, 15);

    // Reset while holding captured load data.
    bus.dmemREN = 1'b1; bus.dhit = 1'b1; bus.ihit = 1'b0; bus.dmemload = 32'hDEADBEEF;
    cyc();
    bus.dhit = 1'b0;
    #1 chk("rst_dhold_data", bus.dload_out, 32'hDEADBEEF);
    nRST = 1'b0; bus.dmemload = 32'h55; bus.ihit = 1'b1;
    #1;
    chk("rstmid_pc_en", bus.pc_en, 1'b0);
    chk("rstmid_mem_wb_en", bus.mem_wb_en, 1'b0);
    chk("rstmid_dload", bus.dload_out, 32'h55);
    chk("rstmid_stall", bus.stall_cnt, 0);
    chk("rstmid_flush", bus.flush_cnt, 0);
    chk("rstmid_suppress", bus.dmem_suppress, 1'b0);
    cyc();
    bus.dmemREN = 1'b0;
    nRST = 1'b1;
    #1;
    chk("rel_pc_en", bus.pc_en, 1'b1);
    chk("rel_suppress", bus.dmem_suppress, 1'b0);
    cyc();

    // Halt drain: final advance completes, then everything freezes.
    bus.halt_mem = 1'b1;
    #1 chk("halt_last_mem_wb_en", bus.mem_wb_en, 1'b1);
    cyc();
    bus.halt_mem = 1'b0;
    #1;
    chk("halt_out", bus.halt_out, 1'b1);
    chk("halt_mem_wb_en", bus.mem_wb_en, 1'b0);
    chk("halt_suppress", bus.dmem_suppress, 1'b1);
    s0 = bus.stall_cnt;
    f0 = bus.flush_cnt;
    bus.branch = 1'b1;
    repeat (100) cyc();
    bus.branch = 1'b0;
    chk("halt_sticky", bus.halt_out, 1'b1);
    chk("halt_pc_en", bus.pc_en, 1'b0);
    chk("halt_stall_frozen", bus.stall_cnt - s0, 0);
    chk("halt_flush_frozen", bus.flush_cnt - f0, 0);
    chk("halt_stall_abs", bus.stall_cnt, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
